// File: rtl/gtxe2_common_pkg.sv
// Shared definitions for the GTXE2 common (QPLL) behavioural model.
// Holds the DRP register addresses, the reference-clock select encodings,
// the refclk idle limit and the lock-threshold reset values.
package gtxe2_common_pkg;

  // DRP register map
  localparam logic [7:0] DRP_ADDR_STATUS  = 8'h00;
  localparam logic [7:0] DRP_ADDR_THRESH  = 8'h01;
  localparam logic [7:0] DRP_ADDR_PARAMS  = 8'h02;
  localparam logic [7:0] DRP_ADDR_SCRATCH = 8'h03;

  // QPLLREFCLKSEL encodings
  typedef enum logic [2:0] {
    REFSEL_NONE    = 3'b000,
    REFSEL_GTREF0  = 3'b001,
    REFSEL_GTREF1  = 3'b010,
    REFSEL_NORTH0  = 3'b011,
    REFSEL_NORTH1  = 3'b100,
    REFSEL_SOUTH0  = 3'b101,
    REFSEL_SOUTH1  = 3'b110,
    REFSEL_GTGREF  = 3'b111
  } refclk_sel_e;

  // Idle cycles without a refclk edge before the refclk is declared lost
  localparam int unsigned LOST_LIMIT = 8;

  // Lock threshold reset values (fast simulation / realistic)
  localparam logic [10:0] LOCK_THRESH_FAST = 11'd32;
  localparam logic [10:0] LOCK_THRESH_SLOW = 11'd1024;

  // Lock counter saturation value
  localparam logic [10:0] LOCK_CNT_MAX = 11'd2047;

endpackage

// File: rtl/gtxe2_common_model_if.sv
// DRP bus of the GTXE2 common model.
//   DRPEN   : access strobe (one cycle per access)
//   DRPWE   : write enable qualifying DRPEN
//   DRPADDR : register address
//   DRPDI   : write data
//   DRPDO   : read data, valid while DRPRDY is high, 0 otherwise
//   DRPRDY  : one-cycle acknowledge, one cycle after DRPEN
// master drives the request side, slave (the model) returns data/ready.
interface gtxe2_common_model_if;
  logic        DRPEN;
  logic        DRPWE;
  logic [7:0]  DRPADDR;
  logic [15:0] DRPDI;
  logic [15:0] DRPDO;
  logic        DRPRDY;

  modport master (
    output DRPEN, DRPWE, DRPADDR, DRPDI,
    input  DRPDO, DRPRDY
  );

  modport slave (
    input  DRPEN, DRPWE, DRPADDR, DRPDI,
    output DRPDO, DRPRDY
  );
endinterface

// File: rtl/gtxe2_refclk_activity.sv
// Reference clock activity monitor.
// The (muxed) reference clock is treated as a data input: it is brought
// through a two-flop synchronizer and any change of the synchronized level
// counts as activity. An idle counter clears on activity and otherwise
// counts up, saturating at LOST_LIMIT; lost is high while it sits there.
// Ports:
//   clk       : lock-detect clock
//   rst_n     : synchronous active-low reset
//   refclk_in : selected reference clock (asynchronous level)
//   lost      : reference clock has shown no edge for LOST_LIMIT cycles
module gtxe2_refclk_activity
  import gtxe2_common_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic refclk_in,
  output logic lost
);

  localparam logic [3:0] IDLE_LIMIT = 4'(LOST_LIMIT);

  logic       sync_p0;
  logic       sync_p1;
  logic       sync_p2;
  logic       activity;
  logic [3:0] idle_cnt;

  // sync_p1 is the synchronized level, sync_p2 its previous value
  assign activity = sync_p1 ^ sync_p2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      sync_p2  <= 1'b0;
      idle_cnt <= '0;
    end else begin
      // stage p0 -> p1: metastability filter
      sync_p0 <= refclk_in;
      sync_p1 <= sync_p0;
      // stage p1 -> p2: previous synchronized level for edge detect
      sync_p2 <= sync_p1;
      if (activity) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_LIMIT) begin
        idle_cnt <= idle_cnt + 4'd1;
      end
    end
  end

  assign lost = (idle_cnt == IDLE_LIMIT);

endmodule

// File: rtl/gtxe2_common_model.sv
// Behavioural model of the GTXE2 common block (QPLL).
// Selects one of seven reference clocks, monitors it for activity and
// declares lock once an 11-bit counter of consecutive lock-enabled cycles
// reaches a programmable threshold.
// Optional feature: define GTXE2_COMMON_DRP_EN to enable the DRP register
// file (status, threshold, parameters, scratch). Without it the DRP returns
// 0, never acknowledges, and the threshold is fixed at its reset value.
// Ports:
//   QPLLLOCKDETCLK : sole clock
//   QPLLRESETN     : synchronous active-low reset
//   GT*REFCLK*     : candidate reference clocks, QPLLREFCLKSEL picks one
//   QPLLPD         : power-down (forces FBCLKLOST, blocks lock)
//   QPLLLOCKEN     : lock-detect enable
//   QPLLOUTRESET   : gates QPLLOUTCLK low
//   QPLLLOCK / QPLLREFCLKLOST / QPLLFBCLKLOST : status
//   QPLLOUTREFCLK  : selected reference clock (combinational)
//   QPLLOUTCLK     : selected refclk gated by lock and not QPLLOUTRESET
//   QPLLDMONITOR   : lock counter [7:0]
//   drp            : DRP bus (slave side)
//   BG*, RCALENB, PMARSVD, QPLLRSVD* : accepted and ignored
module gtxe2_common_model
  import gtxe2_common_pkg::*;
#(
  parameter string       SIM_RESET_SPEEDUP  = "TRUE",
  parameter logic [2:0]  SIM_QPLLREFCLK_SEL = 3'b001,
  parameter logic [9:0]  QPLL_FBDIV         = 10'b0000100000,
  parameter logic        QPLL_FBDIV_RATIO   = 1'b1
) (
  input  logic                  QPLLLOCKDETCLK,
  input  logic                  QPLLRESETN,
  input  logic                  GTREFCLK0,
  input  logic                  GTREFCLK1,
  input  logic                  GTNORTHREFCLK0,
  input  logic                  GTNORTHREFCLK1,
  input  logic                  GTSOUTHREFCLK0,
  input  logic                  GTSOUTHREFCLK1,
  input  logic                  GTGREFCLK,
  input  logic [2:0]            QPLLREFCLKSEL,
  input  logic                  QPLLPD,
  input  logic                  QPLLLOCKEN,
  input  logic                  QPLLOUTRESET,
  output logic                  QPLLLOCK,
  output logic                  QPLLREFCLKLOST,
  output logic                  QPLLFBCLKLOST,
  output logic                  QPLLOUTREFCLK,
  output logic                  QPLLOUTCLK,
  output logic [7:0]            QPLLDMONITOR,
  gtxe2_common_model_if.slave   drp,
  input  logic                  BGBYPASSB,
  input  logic                  BGMONITORENB,
  input  logic                  BGPDB,
  input  logic                  RCALENB,
  input  logic [4:0]            BGRCALOVRD,
  input  logic [7:0]            PMARSVD,
  input  logic [15:0]           QPLLRSVD1,
  input  logic [4:0]            QPLLRSVD2
);

  localparam logic [10:0] THRESH_INIT =
    (SIM_RESET_SPEEDUP == "TRUE") ? LOCK_THRESH_FAST : LOCK_THRESH_SLOW;

  localparam logic [15:0] PARAM_WORD =
    {2'b00, QPLL_FBDIV_RATIO, SIM_QPLLREFCLK_SEL, QPLL_FBDIV};

  logic        refclk_mux;
  logic        refclk_lost;
  logic [2:0]  sel_prev;
  logic        lock_en;
  logic [10:0] lock_cnt;
  logic [10:0] lock_cnt_nxt;
  logic        lock_q;
  logic [10:0] thresh;

  // Reference clock select; 000 deliberately yields a dead clock
  always_comb begin
    refclk_mux = 1'b0;
    case (refclk_sel_e'(QPLLREFCLKSEL))
      REFSEL_NONE:   refclk_mux = 1'b0;
      REFSEL_GTREF0: refclk_mux = GTREFCLK0;
      REFSEL_GTREF1: refclk_mux = GTREFCLK1;
      REFSEL_NORTH0: refclk_mux = GTNORTHREFCLK0;
      REFSEL_NORTH1: refclk_mux = GTNORTHREFCLK1;
      REFSEL_SOUTH0: refclk_mux = GTSOUTHREFCLK0;
      REFSEL_SOUTH1: refclk_mux = GTSOUTHREFCLK1;
      REFSEL_GTGREF: refclk_mux = GTGREFCLK;
      default:       refclk_mux = 1'b0;
    endcase
  end

  gtxe2_refclk_activity u_refclk_activity (
    .clk       (QPLLLOCKDETCLK),
    .rst_n     (QPLLRESETN),
    .refclk_in (refclk_mux),
    .lost      (refclk_lost)
  );

  // Select history is captured even in reset so a select that was stable
  // through reset does not cost an extra disabled cycle afterwards.
  always_ff @(posedge QPLLLOCKDETCLK) begin
    sel_prev <= QPLLREFCLKSEL;
  end

  assign lock_en = !QPLLPD && QPLLLOCKEN && !refclk_lost &&
                   (QPLLREFCLKSEL == sel_prev);

  assign lock_cnt_nxt = (lock_cnt == LOCK_CNT_MAX) ? lock_cnt
                                                   : lock_cnt + 11'd1;

  // Lock is registered against the incremented count so it rises on the
  // same edge the counter reaches the threshold, and stays 0 in reset even
  // when the threshold is programmed to 0.
  always_ff @(posedge QPLLLOCKDETCLK) begin
    if (!QPLLRESETN) begin
      lock_cnt <= '0;
      lock_q   <= 1'b0;
    end else if (lock_en) begin
      lock_cnt <= lock_cnt_nxt;
      lock_q   <= (lock_cnt_nxt >= thresh);
    end else begin
      lock_cnt <= '0;
      lock_q   <= 1'b0;
    end
  end

`ifdef GTXE2_COMMON_DRP_EN
  logic [10:0] thresh_q;
  logic [15:0] scratch_q;
  logic [15:0] rd_data;
  logic [15:0] drpdo_q;
  logic        drprdy_q;

  always_comb begin
    rd_data = '0;
    case (drp.DRPADDR)
      DRP_ADDR_STATUS:  rd_data = {13'b0, lock_q, refclk_lost, QPLLPD};
      DRP_ADDR_THRESH:  rd_data = {5'b0, thresh_q};
      DRP_ADDR_PARAMS:  rd_data = PARAM_WORD;
      DRP_ADDR_SCRATCH: rd_data = scratch_q;
      default:          rd_data = '0;
    endcase
  end

  // Read data is the pre-write register contents on a write access
  always_ff @(posedge QPLLLOCKDETCLK) begin
    if (!QPLLRESETN) begin
      thresh_q  <= THRESH_INIT;
      scratch_q <= '0;
      drprdy_q  <= 1'b0;
      drpdo_q   <= '0;
    end else begin
      drprdy_q <= drp.DRPEN;
      drpdo_q  <= drp.DRPEN ? rd_data : 16'h0000;
      if (drp.DRPEN && drp.DRPWE) begin
        case (drp.DRPADDR)
          DRP_ADDR_THRESH:  thresh_q  <= drp.DRPDI[10:0];
          DRP_ADDR_SCRATCH: scratch_q <= drp.DRPDI;
          default: ;
        endcase
      end
    end
  end

  assign thresh     = thresh_q;
  assign drp.DRPDO  = drpdo_q;
  assign drp.DRPRDY = drprdy_q;
`else
  logic unused_drp;

  assign thresh     = THRESH_INIT;
  assign drp.DRPDO  = 16'h0000;
  assign drp.DRPRDY = 1'b0;
  assign unused_drp = ^{drp.DRPEN, drp.DRPWE, drp.DRPADDR, drp.DRPDI,
                        PARAM_WORD};
`endif

  logic unused_pins;
  assign unused_pins = ^{BGBYPASSB, BGMONITORENB, BGPDB, RCALENB,
                         BGRCALOVRD, PMARSVD, QPLLRSVD1, QPLLRSVD2};

  assign QPLLLOCK       = lock_q;
  assign QPLLREFCLKLOST = refclk_lost;
  assign QPLLFBCLKLOST  = QPLLPD;
  assign QPLLOUTREFCLK  = refclk_mux;
  assign QPLLOUTCLK     = refclk_mux & lock_q & ~QPLLOUTRESET;
  assign QPLLDMONITOR   = lock_cnt[7:0];

endmodule

// File: tb/tb_gtxe2_common_model.sv
// Self-checking bench for gtxe2_common_model: directed scenarios plus a
// randomized phase, all compared every cycle against a reference model
// of the QPLL behaviour kept in this file.
module tb_gtxe2_common_model;

`ifdef GTXE2_COMMON_DRP_EN
  localparam bit DRP_EN = 1'b1;
`else
  localparam bit DRP_EN = 1'b0;
`endif

  logic        QPLLLOCKDETCLK = 1'b0;
  logic        QPLLRESETN;
  logic        GTREFCLK0, GTREFCLK1;
  logic        GTNORTHREFCLK0, GTNORTHREFCLK1;
  logic        GTSOUTHREFCLK0, GTSOUTHREFCLK1, GTGREFCLK;
  logic [2:0]  QPLLREFCLKSEL;
  logic        QPLLPD, QPLLLOCKEN, QPLLOUTRESET;
  logic        QPLLLOCK, QPLLREFCLKLOST, QPLLFBCLKLOST;
  logic        QPLLOUTREFCLK, QPLLOUTCLK;
  logic [7:0]  QPLLDMONITOR;

  gtxe2_common_model_if drp ();

  gtxe2_common_model dut (
    .QPLLLOCKDETCLK (QPLLLOCKDETCLK),
    .QPLLRESETN     (QPLLRESETN),
    .GTREFCLK0      (GTREFCLK0),
    .GTREFCLK1      (GTREFCLK1),
    .GTNORTHREFCLK0 (GTNORTHREFCLK0),
    .GTNORTHREFCLK1 (GTNORTHREFCLK1),
    .GTSOUTHREFCLK0 (GTSOUTHREFCLK0),
    .GTSOUTHREFCLK1 (GTSOUTHREFCLK1),
    .GTGREFCLK      (GTGREFCLK),
    .QPLLREFCLKSEL  (QPLLREFCLKSEL),
    .QPLLPD         (QPLLPD),
    .QPLLLOCKEN     (QPLLLOCKEN),
    .QPLLOUTRESET   (QPLLOUTRESET),
    .QPLLLOCK       (QPLLLOCK),
    .QPLLREFCLKLOST (QPLLREFCLKLOST),
    .QPLLFBCLKLOST  (QPLLFBCLKLOST),
    .QPLLOUTREFCLK  (QPLLOUTREFCLK),
    .QPLLOUTCLK     (QPLLOUTCLK),
    .QPLLDMONITOR   (QPLLDMONITOR),
    .drp            (drp.slave),
    .BGBYPASSB      (1'b1),
    .BGMONITORENB   (1'b1),
    .BGPDB          (1'b1),
    .RCALENB        (1'b1),
    .BGRCALOVRD     (5'b11111),
    .PMARSVD        (8'h00),
    .QPLLRSVD1      (16'h0000),
    .QPLLRSVD2      (5'b11111)
  );

  always #5 QPLLLOCKDETCLK = ~QPLLLOCKDETCLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit run0   = 1'b0;
  bit run1   = 1'b0;
  bit noise  = 1'b0;

  // Reference model state
  int          m_thr     = 32;
  logic [15:0] m_scratch = '0;
  bit          m_samp[3] = '{0, 0, 0};  // refclk as seen 1, 2, 3 edges ago
  int          m_idle    = 0;           // cycles since last synchronized change
  int          m_cnt     = 0;           // consecutive lock-enabled cycles
  bit          m_lock    = 1'b0;
  logic [2:0]  m_sel_prev = 3'b000;
  bit          m_rdy     = 1'b0;
  logic [15:0] m_do      = '0;

  function automatic bit sel_ref(input logic [2:0] s);
    case (s)
      3'd1: return GTREFCLK0;
      3'd2: return GTREFCLK1;
      3'd3: return GTNORTHREFCLK0;
      3'd4: return GTNORTHREFCLK1;
      3'd5: return GTSOUTHREFCLK0;
      3'd6: return GTSOUTHREFCLK1;
      3'd7: return GTGREFCLK;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] m_read(input logic [7:0] a);
    case (a)
      8'h00: return {13'b0, m_lock, (m_idle >= 8), QPLLPD};
      8'h01: return 16'(m_thr);
      8'h02: return 16'h2420;
      8'h03: return m_scratch;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at the edge
  task automatic model_edge();
    bit en;
    bit changed;
    int nxt;
    if (!QPLLRESETN) begin
      m_thr = 32; m_scratch = '0; m_samp = '{0, 0, 0};
      m_idle = 0; m_cnt = 0; m_lock = 0; m_rdy = 0; m_do = '0;
    end else begin
      en = !QPLLPD && QPLLLOCKEN && (m_idle < 8) && (QPLLREFCLKSEL == m_sel_prev);
      changed = (m_samp[1] != m_samp[2]);
      if (DRP_EN && drp.DRPEN) begin
        m_rdy = 1'b1;
        m_do  = m_read(drp.DRPADDR);
      end else begin
        m_rdy = 1'b0;
        m_do  = '0;
      end
      nxt    = en ? ((m_cnt < 2047) ? m_cnt + 1 : 2047) : 0;
      m_lock = en && (nxt >= m_thr);
      m_cnt  = nxt;
      if (DRP_EN && drp.DRPEN && drp.DRPWE) begin
        if (drp.DRPADDR == 8'h01) m_thr = int'(drp.DRPDI[10:0]);
        if (drp.DRPADDR == 8'h03) m_scratch = drp.DRPDI;
      end
      m_idle  = changed ? 0 : ((m_idle < 8) ? m_idle + 1 : 8);
      m_samp[2] = m_samp[1];
      m_samp[1] = m_samp[0];
      m_samp[0] = sel_ref(QPLLREFCLKSEL);
    end
    m_sel_prev = QPLLREFCLKSEL;
  endtask

  task automatic check_outputs();
    bit r;
    r = sel_ref(QPLLREFCLKSEL);
    chk("lock",        QPLLLOCK,       m_lock);
    chk("refclk_lost", QPLLREFCLKLOST, (m_idle >= 8));
    chk("fbclk_lost",  QPLLFBCLKLOST,  QPLLPD);
    chk("dmonitor",    QPLLDMONITOR,   16'(m_cnt % 256));
    chk("drprdy",      drp.DRPRDY,     m_rdy);
    chk("drpdo",       drp.DRPDO,      m_do);
    chk("outrefclk",   QPLLOUTREFCLK,  r);
    chk("outclk",      QPLLOUTCLK,     r & m_lock & ~QPLLOUTRESET);
  endtask

  task automatic tick();
    @(posedge QPLLLOCKDETCLK);
    #1;
    model_edge();
    cyc++;
    check_outputs();
    if (run0 && (cyc % 2 == 0)) GTREFCLK0 = ~GTREFCLK0;
    if (run1 && (cyc % 2 == 1)) GTREFCLK1 = ~GTREFCLK1;
    if (noise) begin
      GTNORTHREFCLK0 = 1'($urandom);
      GTNORTHREFCLK1 = 1'($urandom);
      GTSOUTHREFCLK0 = 1'($urandom);
      GTSOUTHREFCLK1 = 1'($urandom);
      GTGREFCLK      = 1'($urandom);
      QPLLOUTRESET   = ($urandom % 4 == 0);
    end
  endtask

  task automatic drp_access(input logic [7:0] a, input bit we, input logic [15:0] d);
    drp.DRPEN = 1'b1; drp.DRPWE = we; drp.DRPADDR = a; drp.DRPDI = d;
    tick();
    drp.DRPEN = 1'b0; drp.DRPWE = 1'b0;
  endtask

  task automatic wait_lock(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (QPLLLOCK !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    chk(tag, 16'(n), 16'(exp_cycles));
  endtask

  initial begin
    int n;
    logic [15:0] sd;
    QPLLRESETN = 1'b0;
    GTREFCLK0 = 0; GTREFCLK1 = 0; GTNORTHREFCLK0 = 0; GTNORTHREFCLK1 = 0;
    GTSOUTHREFCLK0 = 0; GTSOUTHREFCLK1 = 0; GTGREFCLK = 0;
    QPLLREFCLKSEL = 3'b001; QPLLPD = 0; QPLLLOCKEN = 1; QPLLOUTRESET = 0;
    drp.DRPEN = 0; drp.DRPWE = 0; drp.DRPADDR = '0; drp.DRPDI = '0;

    // Reset state
    repeat (3) tick();
    chk("reset_lock", QPLLLOCK, 1'b0);
    chk("reset_dmon", QPLLDMONITOR, 8'h00);
    chk("reset_lost", QPLLREFCLKLOST, 1'b0);

    // First lock on GTREFCLK0
    run0 = 1; noise = 1; QPLLRESETN = 1'b1;
    wait_lock("lock_latency", 32);
    repeat (10) tick();
    chk("locked_steady", QPLLLOCK, 1'b1);

    // Refclk stops: lost, then lock drops the following cycle
    run0 = 0; run1 = 1;
    n = 0;
    while (QPLLREFCLKLOST !== 1'b1 && n < 40) begin tick(); n++; end
    chk("lost_seen", QPLLREFCLKLOST, 1'b1);
    tick();
    chk("lock_drop_after_lost", QPLLLOCK, 1'b0);

    // Restart: relock 32 cycles after lost clears
    run0 = 1;
    n = 0;
    while (QPLLREFCLKLOST !== 1'b0 && n < 40) begin tick(); n++; end
    chk("lost_cleared", QPLLREFCLKLOST, 1'b0);
    wait_lock("relock_latency", 32);

    // Switch to GTREFCLK1 while locked
    repeat (3) tick();
    QPLLREFCLKSEL = 3'b010;
    tick();
    chk("lock_drop_on_sel", QPLLLOCK, 1'b0);
    wait_lock("relock_ref1", 32);

    // DRP: threshold write/readback, parameter word
    drp_access(8'h01, 1'b1, 16'd16);
    chk("drp_wr_rdy", drp.DRPRDY, DRP_EN);
    tick();
    chk("drp_rdy_pulse", drp.DRPRDY, 1'b0);
    drp_access(8'h01, 1'b0, 16'h0);
    chk("drp_rd_thr", drp.DRPDO, DRP_EN ? 16'h0010 : 16'h0000);
    drp_access(8'h02, 1'b0, 16'h0);
    chk("drp_rd_params", drp.DRPDO, DRP_EN ? 16'h2420 : 16'h0000);
    QPLLLOCKEN = 0;
    tick();
    QPLLLOCKEN = 1;
    wait_lock("lock_new_thr", DRP_EN ? 16 : 32);
    sd = 16'($urandom);
    drp_access(8'h03, 1'b1, sd);
    drp_access(8'h03, 1'b0, 16'h0);
    chk("drp_scratch", drp.DRPDO, DRP_EN ? sd : 16'h0000);
    drp_access(8'h00, 1'b0, 16'h0);
    drp_access(8'h07, 1'b1, 16'hffff);
    drp_access(8'h07, 1'b0, 16'h0);

    // Randomized traffic against the model
    run0 = 1; run1 = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom % 24 == 0) QPLLREFCLKSEL = 3'($urandom);
      QPLLPD     = ($urandom % 40 == 0);
      QPLLLOCKEN = ($urandom % 30 != 0);
      QPLLRESETN = ($urandom % 80 != 0);
      drp.DRPEN  = ($urandom % 6 == 0);
      drp.DRPWE  = 1'($urandom);
      drp.DRPADDR = 8'($urandom_range(0, 5));
      drp.DRPDI  = (drp.DRPADDR == 8'h01) ? 16'($urandom_range(0, 60)) : 16'($urandom);
      tick();
    end
    drp.DRPEN = 0; drp.DRPWE = 0; QPLLRESETN = 1; QPLLLOCKEN = 1;

    // Power-down tie-off: never locks
    QPLLREFCLKSEL = 3'b001; QPLLPD = 1;
    repeat (100) tick();
    chk("pd_no_lock", QPLLLOCK, 1'b0);
    chk("pd_fbclklost", QPLLFBCLKLOST, 1'b1);

    // Reset mid-lock with a DRP access in flight
    QPLLPD = 0; QPLLRESETN = 0;
    tick();
    QPLLRESETN = 1;
    wait_lock("lock_before_reset", 32);
    repeat (5) tick();
    QPLLRESETN = 0;
    drp.DRPEN = 1; drp.DRPADDR = 8'h02;
    tick();
    drp.DRPEN = 0;
    chk("rst_mid_lock", QPLLLOCK, 1'b0);
    chk("rst_mid_dmon", QPLLDMONITOR, 8'h00);
    chk("rst_mid_rdy", drp.DRPRDY, 1'b0);
    chk("rst_mid_do", drp.DRPDO, 16'h0000);
    chk("rst_mid_outclk", QPLLOUTCLK, 1'b0);
    QPLLRESETN = 1;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gtxe2_common_model.md
GTXE2_COMMON_MODEL -- requirements
Module: gtxe2_common_model

Interface
REQ-001 Parameter SIM_RESET_SPEEDUP, default "TRUE": selects the lock threshold reset value; "TRUE" gives 32 cycles, any other value gives 1024.
REQ-002 Parameter SIM_QPLLREFCLK_SEL, default 3'b001: informational; reported in DRP 0x02[12:10].
REQ-003 Parameter QPLL_FBDIV, default 10'b0000100000: informational; reported in DRP 0x02[9:0].
REQ-004 Parameter QPLL_FBDIV_RATIO, default 1'b1: informational; reported in DRP 0x02[13].
REQ-005 QPLLLOCKDETCLK  in  1  sole clock; all logic and the DRP are synchronous to its rising edge.
REQ-006 QPLLRESETN  in  1  synchronous, active-low reset.
REQ-007 GTREFCLK0, GTREFCLK1  in  1 each  local reference clocks, treated as sampled activity inputs.
REQ-008 GTNORTHREFCLK0/1, GTSOUTHREFCLK0/1, GTGREFCLK  in  1 each  alternate reference clocks.
REQ-009 QPLLREFCLKSEL  in  3  reference select: 001 GTREFCLK0, 010 GTREFCLK1, 011 N0, 100 N1, 101 S0, 110 S1, 111 GTGREFCLK, 000 none (constant 0).
REQ-010 QPLLPD  in  1  power-down, active-high.
REQ-011 QPLLLOCKEN  in  1  lock-detect enable.
REQ-012 QPLLOUTRESET  in  1  gates QPLLOUTCLK low while high.
REQ-013 QPLLLOCK  out  1  PLL locked.
REQ-014 QPLLREFCLKLOST  out  1  selected reference clock inactive.
REQ-015 QPLLFBCLKLOST  out  1  feedback lost; equals QPLLPD.
REQ-016 QPLLOUTREFCLK  out  1  combinational mux of the selected reference clock.
REQ-017 QPLLOUTCLK  out  1  QPLLOUTREFCLK AND QPLLLOCK AND NOT QPLLOUTRESET.
REQ-018 QPLLDMONITOR  out  8  lock counter bits [7:0].
REQ-019 DRPEN, DRPWE  in  1 each; DRPADDR  in  8; DRPDI  in  16; DRPDO  out  16; DRPRDY  out  1: DRP port.
REQ-020 BGBYPASSB, BGMONITORENB, BGPDB, RCALENB, BGRCALOVRD[4:0], PMARSVD[7:0], QPLLRSVD1[15:0], QPLLRSVD2[4:0]: inputs accepted and ignored.

Function
REQ-021 Selected refclk passes through a 2-flop synchronizer; an activity edge is any change of the synchronized value.
REQ-022 An idle counter clears on each activity edge and increments (saturating) otherwise; QPLLREFCLKLOST is 1 when the count reaches 8 and returns to 0 on the cycle after the next edge.
REQ-023 Lock is enabled when QPLLPD=0, QPLLLOCKEN=1, QPLLREFCLKLOST=0, and QPLLREFCLKSEL has not changed since the previous cycle.
REQ-024 While enabled, the 11-bit lock counter increments each cycle, saturating at 2047; QPLLLOCK is 1 when counter >= threshold (DRP 0x01).
REQ-025 Any disable condition clears the counter and QPLLLOCK on the next edge; relock restarts the count from 0.
REQ-026 DRP access: DRPEN sampled high -> DRPRDY=1 for exactly one cycle on the next cycle (latency 1); DRPDO is valid with DRPRDY and 0 otherwise.
REQ-027 DRP map: 0x00 RO status {13'b0, QPLLLOCK, QPLLREFCLKLOST, QPLLFBCLKLOST}; 0x01 RW threshold [10:0]; 0x02 RO parameters; 0x03 RW scratch; other addresses read 0 and ignore writes.
REQ-028 A write updates the register on the DRPEN cycle; a threshold change takes effect on the next compare.

Reset
REQ-029 While QPLLRESETN=0: QPLLLOCK=0, QPLLREFCLKLOST=0, counters=0, synchronizers=0, DRPRDY=0, DRPDO=0, threshold=parameter value, scratch=0; a DRP access in flight is dropped.

Configuration
REQ-030 Macro GTXE2_COMMON_DRP_EN defined: DRP as specified. Undefined: DRPDO=0, DRPRDY=0, writes ignored, threshold fixed at the parameter value.

Structure
REQ-031 Shared package gtxe2_common_pkg holds the DRP address constants, the refclk-select encodings, the lost limit (8), and the threshold values (32/1024).
REQ-032 One sub-module, gtxe2_refclk_activity (synchronizer, edge detector, idle counter), instantiated once on the muxed refclk.

Verification
REQ-033 Toggling GTREFCLK0 every 2 cycles, SEL=001, PD=0, LOCKEN=1 after reset -> QPLLLOCK rises after 32 enabled cycles; QPLLOUTCLK follows the refclk.
REQ-034 Refclk stopped while locked -> QPLLREFCLKLOST=1 8 cycles after the last edge, QPLLLOCK=0 the next cycle; restart -> relock after 32 cycles.
REQ-035 QPLLPD=1 (production tie-off) -> QPLLLOCK stays 0 and QPLLFBCLKLOST=1 indefinitely.
REQ-036 SEL 001->010 while locked -> lock drops for at least 1 cycle, then relocks after 32 cycles on GTREFCLK1.
REQ-037 DRP write 0x01=16 then read 0x01 -> DRPRDY pulses 1 cycle each, DRPDO=0x0010; the following lock occurs after 16 cycles; read 0x02 -> 0x2420.
REQ-038 QPLLRESETN low mid-lock -> all outputs reach reset values at the next edge.
